// File: rtl/pipelined_skip_adder_if.sv
// pipelined_skip_adder_if: operand/result handshake bundle for pipelined_skip_adder
interface pipelined_skip_adder_if #(parameter int WIDTH = 32);
   logic             in_valid, in_ready, cin, sub;
   logic             out_valid, out_ready, cout, of;
   logic [WIDTH-1:0] a, b, sum;
   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, sum, cout, of);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, sum, cout, of);
endinterface

// File: rtl/pipelined_skip_adder.sv
// pipelined_skip_adder: pipelined carry-skip add/sub with valid/ready; define PSA_SATURATE_EN to clamp overflowing sums
module pipelined_skip_adder #(
   parameter int WIDTH  = 32,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input logic clk,
   input logic rst_n,
   pipelined_skip_adder_if.slave bus
);
   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / GROUP;
   logic             adv;
   logic [WIDTH-1:0] xa [STAGES];
   logic [WIDTH-1:0] xb [STAGES];
   logic [WIDTH-1:0] xs [STAGES];
   logic [WIDTH-1:0] ns [STAGES];
   logic [WIDTH-1:0] ra [STAGES];
   logic [WIDTH-1:0] rb [STAGES];
   logic [WIDTH-1:0] rs [STAGES];
   logic [STAGES-1:0] xc, nc, rc, rv, vnext;
   logic             of_n, rof, c, gci, p, t;
   int               n;
   assign adv           = !rv[STAGES-1] || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = rv[STAGES-1];
   assign bus.sum       = rs[STAGES-1];
   assign bus.cout      = rc[STAGES-1];
   assign bus.of        = rof;
   generate
      if (STAGES == 1) begin : g_v1
         assign vnext = bus.in_valid;
      end else begin : g_vn
         assign vnext = {rv[STAGES-2:0], bus.in_valid};
      end
   endgenerate
   // stage k adds its slice from stage k-1's registers; finished lower slices ride along
   always_comb begin
      c    = 1'b0;
      gci  = 1'b0;
      p    = 1'b0;
      t    = 1'b0;
      n    = 0;
      nc   = '0;
      xc   = '0;
      xa[0] = bus.a;
      xb[0] = bus.sub ? ~bus.b : bus.b;
      xc[0] = bus.sub ? 1'b1 : bus.cin;
      xs[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         xa[k] = ra[k-1];
         xb[k] = rb[k-1];
         xc[k] = rc[k-1];
         xs[k] = rs[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         ns[k] = xs[k];
         c     = xc[k];
         for (int g = 0; g < NG; g++) begin
            gci = c;
            p   = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
               n        = k * SW + g * GROUP + j;
               t        = xa[k][n] ^ xb[k][n];
               ns[k][n] = t ^ c;
               c        = (xa[k][n] & xb[k][n]) | (t & c);
               p        = p & t;
            end
            c = p ? gci : c;
         end
         nc[k] = c;
      end
      of_n = (xa[STAGES-1][WIDTH-1] == xb[STAGES-1][WIDTH-1]) &&
             (ns[STAGES-1][WIDTH-1] != xa[STAGES-1][WIDTH-1]);
`ifdef PSA_SATURATE_EN
      ns[STAGES-1] = of_n ? {xa[STAGES-1][WIDTH-1], {(WIDTH-1){~xa[STAGES-1][WIDTH-1]}}} : ns[STAGES-1];
`else
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rv  <= '0;
         rc  <= '0;
         rof <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            ra[k] <= '0;
            rb[k] <= '0;
            rs[k] <= '0;
         end
      end else if (adv) begin
         rv  <= vnext;
         rc  <= nc;
         rof <= of_n;
         for (int k = 0; k < STAGES; k++) begin
            ra[k] <= xa[k];
            rb[k] <= xb[k];
            rs[k] <= ns[k];
         end
      end
   end
endmodule

// File: tb/tb_pipelined_skip_adder.sv
// tb_pipelined_skip_adder: scoreboard bench for pipelined_skip_adder (default config plus a width/group/stage sweep)
module tb_pipelined_skip_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic rand_rdy = 1'b0;
   logic sweep_go = 1'b0;
   logic [65:0] q[$];
   int   pop_log[$];
   localparam int SWW [3] = '{16, 32, 64};
   localparam int SWG [3] = '{4, 8, 4};
   localparam int SWS [3] = '{1, 4, 2};

   pipelined_skip_adder_if #(.WIDTH(32)) bus ();
   pipelined_skip_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // reference: plain integer arithmetic on w-bit operands, returns {of, cout, sum}
   function automatic logic [65:0] model(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
      logic [63:0] m, s;
      logic [65:0] full;
      logic co, ov;
      logic signed [65:0] sa, sb, r, lim;
      m  = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
      a  = a & m;
      b  = b & m;
      sa = a[w-1] ? $signed({2'b0, a} - (66'd1 << w)) : $signed({2'b0, a});
      sb = b[w-1] ? $signed({2'b0, b} - (66'd1 << w)) : $signed({2'b0, b});
      if (sub) begin
         s  = (a - b) & m;
         co = (a >= b);
         r  = sa - sb;
      end else begin
         full = {2'b0, a} + {2'b0, b} + {65'd0, cin};
         s    = full[63:0] & m;
         co   = full[w];
         r    = sa + sb + $signed({65'd0, cin});
      end
      lim = $signed(66'd1 << (w - 1));
      ov  = (r >= lim) || (r < -lim);
`ifdef PSA_SATURATE_EN
      if (ov) s = a[w-1] ? (64'd1 << (w - 1)) : (64'd1 << (w - 1)) - 64'd1;
`endif
      return {ov, co, s};
   endfunction

   task automatic send(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
      logic acc;
      int   tries;
      bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 1000) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         tries++;
      end
      check("accepted", {63'd0, acc}, 64'd1);
      if (acc) q.push_back(model(32, {32'd0, a}, {32'd0, b}, cin, sub));
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_empty", q.size(), 0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      logic [65:0] e;
      logic        pstall;
      logic [33:0] pout;
      pstall = 1'b0;
      pout   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) pstall = 1'b0;
         else begin
            if (pstall) begin
               check("stall_hold_valid", {63'd0, bus.out_valid}, 64'd1);
               check("stall_hold_data", {30'd0, bus.of, bus.cout, bus.sum}, {30'd0, pout});
            end
            if (bus.out_valid && bus.out_ready) begin
               check("output_expected", {63'd0, q.size() != 0}, 64'd1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  check("sum", {32'd0, bus.sum}, {32'd0, e[31:0]});
                  check("cout", {63'd0, bus.cout}, {63'd0, e[64]});
                  check("of", {63'd0, bus.of}, {63'd0, e[65]});
                  pop_log.push_back(cyc);
               end
            end
            pstall = bus.out_valid && !bus.out_ready;
            pout   = {bus.of, bus.cout, bus.sum};
         end
      end
   end

   for (genvar i = 0; i < 3; i++) begin : sw
      localparam int W = SWW[i];
      logic done = 1'b0;
      logic [65:0] sq[$];
      pipelined_skip_adder_if #(.WIDTH(W)) sif ();
      pipelined_skip_adder #(.WIDTH(W), .GROUP(SWG[i]), .STAGES(SWS[i])) u (
         .clk(clk), .rst_n(rst_n), .bus(sif.slave));
      initial begin
         logic [63:0] x, y;
         logic        ci, sb;
         sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.cin = 1'b0; sif.sub = 1'b0; sif.out_ready = 1'b1;
         wait (sweep_go);
         @(posedge clk);
         #1;
         for (int n = 0; n < 40; n++) begin
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            sif.a = x[W-1:0]; sif.b = y[W-1:0]; sif.cin = ci; sif.sub = sb; sif.in_valid = 1'b1;
            @(negedge clk);
            check("sweep_in_ready", {63'd0, sif.in_ready}, 64'd1);
            sq.push_back(model(W, x, y, ci, sb));
            @(posedge clk);
            #1;
         end
         sif.in_valid = 1'b0;
         repeat (10) @(posedge clk);
         check("sweep_drained", sq.size(), 0);
         done = 1'b1;
      end
      initial begin
         logic [65:0] e;
         forever begin
            @(negedge clk);
            if (rst_n && sif.out_valid && sif.out_ready) begin
               check("sweep_output_expected", {63'd0, sq.size() != 0}, 64'd1);
               if (sq.size() != 0) begin
                  e = sq.pop_front();
                  check("sweep_sum", 64'(sif.sum), 64'(e[W-1:0]));
                  check("sweep_cout", {63'd0, sif.cout}, {63'd0, e[64]});
                  check("sweep_of", {63'd0, sif.of}, {63'd0, e[65]});
               end
            end
         end
      end
   end

   initial begin
      int span, t;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
      #3;
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_sum", {32'd0, bus.sum}, 64'd0);
      check("rst_cout", {63'd0, bus.cout}, 64'd0);
      check("rst_of", {63'd0, bus.of}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("latency_not_early", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk);
      #1;
      check("latency_valid", {63'd0, bus.out_valid}, 64'd1);
      check("skip_chain_sum", {32'd0, bus.sum}, 64'd0);
      check("skip_chain_cout", {63'd0, bus.cout}, 64'd1);
      check("skip_chain_of", {63'd0, bus.of}, 64'd0);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send(32'd5, 32'd7, 1'b1, 1'b1);
      drain();
      pop_log.delete();
      for (int k = 0; k < 100; k++)
         send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();
      span = (pop_log.size() > 0) ? pop_log[pop_log.size()-1] - pop_log[0] : -1;
      check("b2b_count", pop_log.size(), 100);
      check("b2b_span", span, 99);
      pop_log.delete();
      rand_rdy = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rand_rdy = 1'b0;
      bus.out_ready = 1'b1;
      drain();
      check("rand_count", pop_log.size(), 100);
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      send(32'h0000_0009, 32'h0000_0003, 1'b0, 1'b1);
      check("pre_reset_valid", {63'd0, bus.out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("reset_async_valid", {63'd0, bus.out_valid}, 64'd0);
      check("reset_async_sum", {32'd0, bus.sum}, 64'd0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("no_stale_result", {63'd0, bus.out_valid}, 64'd0);
      end
      sweep_go = 1'b1;
      t = 0;
      while (!(sw[0].done && sw[1].done && sw[2].done) && t < 2000) begin
         @(posedge clk);
         t++;
      end
      check("sweep_done", {63'd0, sw[0].done && sw[1].done && sw[2].done}, 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pipelined_skip_adder.md
# pipelined_skip_adder

Parametrised, pipelined carry-skip adder/subtractor with a valid/ready handshake on both sides. It is the next-generation datapath adder for the ALU/arithmetic cluster: it replaces the fixed 32-bit combinational carry-skip adder with a configurable width, skip-group size and pipeline depth. Each pipeline stage contains ripple-carry groups with skip multiplexers. It produces sum, carry-out and signed overflow at a fixed latency.

## Interface
- `WIDTH`, 32: operand/sum width; must be a multiple of `STAGES*GROUP`.
- `GROUP`, 4: bits per ripple group; each group has a propagate-driven skip mux.
- `STAGES`, 2: pipeline stages (≥1); each stage handles `WIDTH/STAGES` bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block accepts operands this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry-in; ignored when `sub`=1.
- `sub` in 1: 0 = A+B+cin, 1 = A−B (A+~B+1).
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `sum` out WIDTH: result.
- `cout` out 1: carry out of the MSB (unsigned carry; for subtract, 1 = no borrow).
- `of` out 1: signed overflow.

## Operation
- Stage k (0-based) adds bit slice [(k+1)·W/S−1 : k·W/S], where W = `WIDTH` and S = `STAGES`.
  - Carry into stage 0 is `sub ? 1 : cin`. Operand B is pre-inverted when `sub`=1.
  - Inside a stage, group i's carry-out = P_i ? group carry-in : ripple carry-out. P_i is the AND of bitwise a^b' over the group.
- Carry-in to stage k>0 is the carry registered at the end of stage k−1.
  - Upper operand slices are delay-registered alongside.
  - Completed lower sum slices are delay-registered forward, so that all slices of a transaction emerge together.
- Each stage register holds a valid bit.
- Global advance enable: `adv = !out_valid || out_ready`. When `adv`=0, every stage holds its contents, so no bubbles are squeezed.
- `in_ready = adv`. A transfer occurs on `in_valid && in_ready`.
- Output transfer occurs on `out_valid && out_ready`.
- `of` = (a[W−1] == b'[W−1]) && (raw_sum[W−1] != a[W−1]), where b' is B after optional inversion. It is computed in the final stage.
- Results are bit-exact to the (W+1)-bit sum a + b' + carry_in.

## Timing
- Reset (`rst_n`=0, asynchronous): all stage valid bits = 0, `out_valid`=0, `sum`=0, `cout`=0, `of`=0.
  - `in_ready` is 1 during and after reset; it is combinational from `out_valid`/`out_ready`.
- Latency: a transaction accepted at edge n appears with `out_valid`=1 after edge n+`STAGES−1`, i.e. it is valid in the cycle following edge n+`STAGES−1`.
  - With `STAGES`=1, the output register is the only register.
- Throughput: one result per cycle while `out_ready`=1.
- Stall: `out_valid`=1 and `out_ready`=0:
  - all stages and outputs hold;
  - `in_ready`=0;
  - `sum`/`cout`/`of` are stable until the transfer.
- Simultaneous accept and output transfer in one cycle is required and loses no data.
- Reset mid-operation: all in-flight transactions are discarded; no partial result is emitted.
- Critical path per stage: one ripple group + (W/S/GROUP) skip muxes + one ripple group.

## Configuration
- `PSA_SATURATE_EN` defined:
  - when `of`=1, `sum` is clamped to the signed limit: 0111…1 if a[W−1]=0, else 1000…0;
  - `of` is still reported;
  - `cout` is unaffected.
- Undefined: `sum` wraps modulo 2^WIDTH, and no clamp logic is synthesised.

## Test plan
- Reset, then WIDTH=32/STAGES=2 with a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0 → after 2 edges: sum=0, cout=1, of=0. This exercises a full-width skip chain across the stage boundary.
- a=0x7FFF_FFFF, b=1, add → of=1, cout=0.
  - Without macro: sum=0x8000_0000.
  - With `PSA_SATURATE_EN`: sum=0x7FFF_FFFF.
- a=5, b=7, sub=1, cin=1 → sum=0xFFFF_FFFE, cout=0 (borrow), of=0; cin is ignored.
- Back-to-back stream of 100 random operations with out_ready=1 → one result per cycle, in order, matching the reference model. Then repeat with random out_ready toggling → no loss or duplication, and outputs stable while stalled.
- Assert rst_n=0 with 2 transactions in flight → out_valid falls immediately and stays 0 after release; no stale result appears.
- Parameter sweep (WIDTH,GROUP,STAGES) = (16,4,1), (32,8,4), (64,4,2) with a random compare against a+b' plus carry-in.
